// File: rtl/enigma_rotor_stepper.sv
// enigma_rotor_stepper
// Rotor-position controller for the Enigma datapath. Each accepted keypress
// advances the three rotor offsets, then waits a settle window before
// pulsing step_done so the combinational cipher path can be latched.
//
// Build option: define DOUBLE_STEP_EN for historical Enigma I stepping
// (middle-rotor double step). Without it the rotors step like an odometer.
//
// state  | meaning
// IDLE   | waiting for a key or a load
// SETTLE | positions updated, counting down the settle window
// DONE   | step_done high for this single cycle

module enigma_rotor_stepper #(
    parameter int NOTCH1        = 16,
    parameter int NOTCH2        = 4,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic       load,
    input  logic [4:0] load_pos1,
    input  logic [4:0] load_pos2,
    input  logic [4:0] load_pos3,
    output logic [4:0] rotate1,
    output logic [4:0] rotate2,
    output logic [4:0] rotate3,
    output logic       busy,
    output logic       step_done,
    output logic       key_drop
);

    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

    localparam logic [4:0] N1       = 5'(NOTCH1);
    localparam logic [4:0] N2       = 5'(NOTCH2);
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    state_t     state, state_nx;
    logic [3:0] cnt, cnt_nx;
    logic [4:0] rot1_nx, rot2_nx, rot3_nx;
    logic       busy_nx, done_nx, drop_nx;
    logic       adv2, adv3;

    function automatic logic [4:0] wrap_inc(input logic [4:0] p);
        return (p >= 5'd25) ? 5'd0 : p + 5'd1;
    endfunction

    // Load values 26..31 fold back into the 0..25 range.
    function automatic logic [4:0] mod26(input logic [4:0] v);
        return (v >= 5'd26) ? v - 5'd26 : v;
    endfunction

    // Turnover decisions on the pre-step positions.
    always_comb begin
`ifdef DOUBLE_STEP_EN
        adv2 = (rotate1 == N1) || (rotate2 == N2);
        adv3 = (rotate2 == N2);
`else
        adv2 = (rotate1 == N1);
        adv3 = (rotate2 == N2) && (rotate1 == N1);
`endif
    end

    // Next-state and next-output logic; load overrides everything.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        rot1_nx  = rotate1;
        rot2_nx  = rotate2;
        rot3_nx  = rotate3;
        busy_nx  = busy;
        done_nx  = 1'b0;
        drop_nx  = 1'b0;
        if (load) begin
            rot1_nx  = mod26(load_pos1);
            rot2_nx  = mod26(load_pos2);
            rot3_nx  = mod26(load_pos3);
            state_nx = IDLE;
            busy_nx  = 1'b0;
            cnt_nx   = 4'd0;
            drop_nx  = key_valid;
        end else begin
            case (state)
                IDLE: begin
                    if (key_valid) begin
                        rot1_nx  = wrap_inc(rotate1);
                        if (adv2) rot2_nx = wrap_inc(rotate2);
                        if (adv3) rot3_nx = wrap_inc(rotate3);
                        state_nx = SETTLE;
                        busy_nx  = 1'b1;
                        cnt_nx   = CNT_INIT;
                    end
                end
                SETTLE: begin
                    drop_nx = key_valid;
                    if (cnt == 4'd0) begin
                        state_nx = DONE;
                        done_nx  = 1'b1;
                    end else begin
                        cnt_nx = cnt - 4'd1;
                    end
                end
                DONE: begin
                    drop_nx  = key_valid;
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
                default: begin
                    state_nx = IDLE;
                    busy_nx  = 1'b0;
                end
            endcase
        end
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            rotate1   <= 5'd0;
            rotate2   <= 5'd0;
            rotate3   <= 5'd0;
            busy      <= 1'b0;
            step_done <= 1'b0;
            key_drop  <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            rotate1   <= rot1_nx;
            rotate2   <= rot2_nx;
            rotate3   <= rot3_nx;
            busy      <= busy_nx;
            step_done <= done_nx;
            key_drop  <= drop_nx;
        end
    end

endmodule
